// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// State encoding and counter sizing helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sub_bit_slice.sv
// One-bit full subtractor: d = a - b - bin.
// Purely combinational; reused every cycle by the serial datapath.
module sub_bit_slice (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic s_d;
  logic s_bout;

  sub_bit_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (s_d),
    .bout (s_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = s_bout;
        acc_d = acc_q >> 1;
        acc_d[WIDTH-1] = s_d;
        cnt_d = cnt_q + 1'b1;
        // Publish only the complete word, never a partial shift.
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = acc_d;
          bout_d  = s_bout;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = br_q ^ s_bout;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor, WIDTH=8.
// Checks handshake timing, results, hold behaviour and reset abort.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;
  int bcnt;
  int dcnt;
  int unheld;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
    .bout  (bout),
    .ovf   (ovf)
`else
    .bout  (bout)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
    chk(tag, {31'd0, ovf}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("no ovf %s", tag);
`endif
  endtask

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    bin   = bi;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Samples #1 after each edge until done, bounded to 20 cycles.
  task automatic wait_done(input logic [W-1:0] hold, output int c,
                           output int bc, output int uh);
    c  = 0;
    bc = 0;
    uh = 0;
    while (!done && c < 20) begin
      if (busy) bc++;
      if (diff !== hold) uh++;
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    chk_ovf("rst_ovf", 1'b0);

    // rst wins over start on the same edge
    start = 1'b1;
    a = 8'h05;
    b = 8'h03;
    @(posedge clk);
    #1;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst = 1'b0;

    // 1: 05 - 03
    start_op(8'h05, 8'h03, 1'b0);
    wait_done(8'h00, cyc, bcnt, unheld);
    chk("t1_lat", cyc, 32'd8);
    chk("t1_busy_cycles", bcnt, 32'd8);
    chk("t1_no_partial", unheld, 32'd0);
    chk("t1_diff", {24'd0, diff}, 32'h02);
    chk("t1_bout", {31'd0, bout}, 32'd0);
    chk("t1_busy_in_done", {31'd0, busy}, 32'd0);
    chk_ovf("t1_ovf", 1'b0);
    @(posedge clk);
    #1;
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_hold", {24'd0, diff}, 32'h02);

    // 2: 00 - 01
    start_op(8'h00, 8'h01, 1'b0);
    wait_done(8'h02, cyc, bcnt, unheld);
    chk("t2_lat", cyc, 32'd8);
    chk("t2_diff", {24'd0, diff}, 32'hFF);
    chk("t2_bout", {31'd0, bout}, 32'd1);
    chk_ovf("t2_ovf", 1'b0);

    // 3a: 80 - 01
    start_op(8'h80, 8'h01, 1'b0);
    wait_done(8'hFF, cyc, bcnt, unheld);
    chk("t3a_diff", {24'd0, diff}, 32'h7F);
    chk("t3a_bout", {31'd0, bout}, 32'd0);
    chk_ovf("t3a_ovf", 1'b1);

    // 3b: 7F - FF
    start_op(8'h7F, 8'hFF, 1'b0);
    wait_done(8'h7F, cyc, bcnt, unheld);
    chk("t3b_diff", {24'd0, diff}, 32'h80);
    chk("t3b_bout", {31'd0, bout}, 32'd1);
    chk_ovf("t3b_ovf", 1'b1);

    // 4: 10 - 10 - 1, second start during RUN ignored
    start_op(8'h10, 8'h10, 1'b1);
    @(negedge clk);
    start = 1'b1;
    a = 8'h33;
    b = 8'h11;
    bin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(8'h80, cyc, bcnt, unheld);
    chk("t4_lat", cyc, 32'd7);
    chk("t4_diff", {24'd0, diff}, 32'hFF);
    chk("t4_bout", {31'd0, bout}, 32'd1);
    chk_ovf("t4_ovf", 1'b0);
    dcnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("t4_single_done", dcnt, 32'd0);
    chk("t4_hold", {24'd0, diff}, 32'hFF);

    // 5: back-to-back start in DONE cycle
    start_op(8'h05, 8'h03, 1'b0);
    wait_done(8'hFF, cyc, bcnt, unheld);
    chk("t5a_diff", {24'd0, diff}, 32'h02);
    start = 1'b1;
    a = 8'h20;
    b = 8'h01;
    bin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd1);
    chk("t5_done_low", {31'd0, done}, 32'd0);
    wait_done(8'h02, cyc, bcnt, unheld);
    chk("t5_lat", cyc, 32'd8);
    chk("t5_held", unheld, 32'd0);
    chk("t5b_diff", {24'd0, diff}, 32'h1F);
    chk("t5b_bout", {31'd0, bout}, 32'd0);
    chk_ovf("t5b_ovf", 1'b0);

    // 6: reset at bit 4 aborts the operation
    start_op(8'h80, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_diff", {24'd0, diff}, 32'd0);
    chk("t6_bout", {31'd0, bout}, 32'd0);
    dcnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("t6_no_done", dcnt, 32'd0);
    start_op(8'h7F, 8'hFF, 1'b0);
    wait_done(8'h00, cyc, bcnt, unheld);
    chk("t6_fresh_lat", cyc, 32'd8);
    chk("t6_fresh_diff", {24'd0, diff}, 32'h80);
    chk("t6_fresh_bout", {31'd0, bout}, 32'd1);
    chk_ovf("t6_fresh_ovf", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
